// File: rtl/bts_pkg.sv
// Shared definitions for the LDM/STM block transfer sequencer.
package bts_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_XFER   = 3'd2,
        ST_BASEWB = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/lowest_set_bit_16.sv
// Priority encoder: index of the lowest set bit of a 16-bit vector.
module lowest_set_bit_16 (
    input  logic [15:0] i_vec,
    output logic [3:0]  o_idx,
    output logic        o_none
);

    // Scan from the top so the lowest set bit is the last one to win
    always_comb begin
        o_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            o_idx = i_vec[i] ? 4'(i) : o_idx;
        end
    end

    assign o_none = ~|i_vec;

endmodule

// File: rtl/block_transfer_sequencer.sv
// LDM/STM sequencer: walks a register list issuing one memory transfer per
// register, then optionally writes back the updated base register.
module block_transfer_sequencer
    import bts_pkg::*;
#(
    parameter int WORD_BYTES = bts_pkg::WORD_BYTES
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        load_in,
    input  logic        pre_in,
    input  logic        up_in,
    input  logic        wb_in,
    input  logic [3:0]  base_reg_in,
    input  logic [31:0] base_val_in,
    input  logic [15:0] reg_list_in,
    output logic [3:0]  rf_addr_out,
    input  logic [31:0] rf_rdata_in,
    output logic [31:0] rf_wdata_out,
    output logic        rf_we_out,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    input  logic        mem_ack_in,
    input  logic [31:0] mem_rdata_in,
    output logic        pc_load_out,
    output logic [31:0] pc_data_out,
    output logic        busy_out,
    output logic        done_out
);

    state_t      r_state;
    logic        r_load;
    logic        r_pre;
    logic        r_up;
    logic        r_wb;
    logic [3:0]  r_base_reg;
    logic [31:0] r_base_val;
    logic [15:0] r_list;
    logic [15:0] r_orig_list;
    logic [31:0] r_addr;
    logic [31:0] r_final_base;

    logic [3:0]  w_cur_idx;
    logic        w_list_none;
    logic [15:0] w_list_next;
    logic [4:0]  w_popcnt;
    logic [31:0] w_nbytes;
    logic [31:0] w_step;
    logic        w_basewb_en;

    lowest_set_bit_16 u_lsb (
        .i_vec  (r_list),
        .o_idx  (w_cur_idx),
        .o_none (w_list_none)
    );

    // Number of registers in the latched list
    always_comb begin
        w_popcnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_popcnt = w_popcnt + {4'd0, r_list[i]};
        end
    end

    assign w_step      = 32'(WORD_BYTES);
    assign w_nbytes    = 32'(w_popcnt) * w_step;
    assign w_list_next = r_list & ~(16'd1 << w_cur_idx);
    // A loaded base register keeps its loaded value; R15 is owned by the PC
    assign w_basewb_en = ~(r_load & r_orig_list[r_base_reg]) & (r_base_reg != 4'd15);

    // Sequencer state and latched transfer context
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= ST_IDLE;
            r_load       <= 1'b0;
            r_pre        <= 1'b0;
            r_up         <= 1'b0;
            r_wb         <= 1'b0;
            r_base_reg   <= 4'd0;
            r_base_val   <= 32'd0;
            r_list       <= 16'd0;
            r_orig_list  <= 16'd0;
            r_addr       <= 32'd0;
            r_final_base <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_in) begin
                        r_load      <= load_in;
                        r_pre       <= pre_in;
                        r_up        <= up_in;
                        r_wb        <= wb_in;
                        r_base_reg  <= base_reg_in;
                        r_base_val  <= base_val_in;
                        r_list      <= reg_list_in;
                        r_orig_list <= reg_list_in;
                        r_state     <= ST_SETUP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    case ({r_pre, r_up})
                        2'b01:   r_addr <= r_base_val;
                        2'b11:   r_addr <= r_base_val + w_step;
                        2'b00:   r_addr <= r_base_val - w_nbytes + w_step;
                        default: r_addr <= r_base_val - w_nbytes;
                    endcase
                    r_final_base <= r_up ? (r_base_val + w_nbytes) : (r_base_val - w_nbytes);
                    r_state      <= w_list_none ? ST_DONE : ST_XFER;
                end
                ST_XFER: begin
                    if (mem_ack_in) begin
                        r_list <= w_list_next;
                        r_addr <= r_addr + w_step;
                        if (w_list_next == 16'd0) begin
                            r_state <= r_wb ? ST_BASEWB : ST_DONE;
                        end else begin
                            r_state <= ST_XFER;
                        end
                    end else begin
                        r_state <= ST_XFER;
                    end
                end
                ST_BASEWB: r_state <= ST_DONE;
                ST_DONE:   r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Output decode from state, plus same-cycle ack/read data
    always_comb begin
        rf_addr_out   = 4'd0;
        rf_wdata_out  = 32'd0;
        rf_we_out     = 1'b0;
        mem_req_out   = 1'b0;
        mem_we_out    = 1'b0;
        mem_addr_out  = 32'd0;
        mem_wdata_out = 32'd0;
        pc_load_out   = 1'b0;
        pc_data_out   = 32'd0;
        done_out      = 1'b0;
        busy_out      = (r_state != ST_IDLE);
        case (r_state)
            ST_XFER: begin
                rf_addr_out  = w_cur_idx;
                mem_req_out  = 1'b1;
                mem_addr_out = r_addr;
                mem_we_out   = ~r_load;
                if (!r_load) begin
                    mem_wdata_out = rf_rdata_in;
                end else if (mem_ack_in && (w_cur_idx == 4'd15)) begin
                    pc_load_out = 1'b1;
                    pc_data_out = mem_rdata_in;
                end else if (mem_ack_in) begin
                    rf_we_out    = 1'b1;
                    rf_wdata_out = mem_rdata_in;
                end else begin
                    rf_we_out = 1'b0;
                end
            end
            ST_BASEWB: begin
                if (w_basewb_en) begin
                    rf_addr_out  = r_base_reg;
                    rf_wdata_out = r_final_base;
                    rf_we_out    = 1'b1;
                end else begin
                    rf_we_out = 1'b0;
                end
            end
            ST_DONE: done_out = 1'b1;
            default: done_out = 1'b0;
        endcase
    end

endmodule

// File: doc/block_transfer_sequencer.md
# block_transfer_sequencer

Multi-cycle sequencer for ARM block data transfers (LDM/STM). On a start pulse it walks a 16-bit register list lowest-to-highest, driving the register file address/write port and a single-outstanding memory request/acknowledge interface. When the writeback bit is set it finishes with a base-register update. It sits between the decode stage and the register file/data memory, and stalls the core through `busy_out` while active.

## Interface
- Parameters:
  - `WORD_BYTES`, 4: address step per transferred register.
- Ports:
  - `clk_in`  input  1  clock, rising edge.
  - `rst_in`  input  1  synchronous, active-high reset.
  - `start_in`  input  1  begin transfer; sampled only in IDLE.
  - `load_in`  input  1  1 = LDM, 0 = STM (L bit).
  - `pre_in` / `up_in` / `wb_in`  input  1 each  P, U and W bits.
  - `base_reg_in`  input  4  base register number (instr[19:16]).
  - `base_val_in`  input  32  base register value at start.
  - `reg_list_in`  input  16  register list (instr[15:0]).
  - `rf_addr_out`  output  4  register file port-B address.
  - `rf_rdata_in`  input  32  register file port-B read data (asynchronous read).
  - `rf_wdata_out`  output  32  register file write data.
  - `rf_we_out`  output  1  register file write enable.
  - `mem_req_out`  output  1  memory request.
  - `mem_we_out`  output  1  1 = store.
  - `mem_addr_out`  output  32  word address.
  - `mem_wdata_out`  output  32  store data.
  - `mem_ack_in`  input  1  request completes in this cycle; load data is valid this cycle.
  - `mem_rdata_in`  input  32  load data.
  - `pc_load_out`  output  1  one-cycle pulse: R15 loaded.
  - `pc_data_out`  output  32  new PC value, valid with `pc_load_out`.
  - `busy_out`  output  1  high in every state except IDLE.
  - `done_out`  output  1  one-cycle completion pulse.

## Operation
- **States:** IDLE → SETUP → XFER → (BASEWB) → DONE → IDLE.
- **IDLE:**
  - On `start_in`, latch the control bits, `base_reg`, `base_val` and `reg_list`.
  - Go to SETUP.
- **SETUP:** compute the 5-bit popcount n, the start address and the final base.
  - Start address, by mode:
    - IA (P=0, U=1): base.
    - IB (P=1, U=1): base+4.
    - DA (P=0, U=0): base−4n+4.
    - DB (P=1, U=0): base−4n.
  - Final base is base+4n (U=1) or base−4n (U=0).
  - All arithmetic is 32-bit modulo 2^32 and wraps silently.
- **Empty list (n=0):** skip XFER and BASEWB and go directly to DONE. No memory or register file activity occurs.
- **XFER:**
  - The current register is the lowest set bit of the remaining list. Drive `rf_addr_out` with it and hold `mem_req_out` high with the current address.
  - Store: `mem_we_out`=1 and `mem_wdata_out`=`rf_rdata_in`.
  - Load: `mem_we_out`=0. On the ack cycle, `rf_we_out`=1 and `rf_wdata_out`=`mem_rdata_in`.
  - On ack: clear that bit and advance the address by 4.
  - When the list becomes empty, go to BASEWB if `wb_in`, otherwise DONE.
- **Load to R15:**
  - Never asserts `rf_we_out`, because the register file overwrites R15 from the PC every cycle.
  - Instead pulses `pc_load_out` with `pc_data_out`=`mem_rdata_in` on the ack cycle.
- **BASEWB:**
  - One cycle: `rf_addr_out`=`base_reg`, `rf_wdata_out`=final base, `rf_we_out`=1.
  - Suppressed (no write, state still visited) when the transfer is a load and the base is in the list; the loaded value wins.
  - Suppressed when `base_reg`=15.
- **DONE:** `done_out`=1 for one cycle, then IDLE.
- **Output defaults:** outside the cases above, all enables and pulses are 0, and address/data outputs are 0.

## Timing
- **Reset:** applied on the rising edge with `rst_in`=1. Clears state to IDLE and every output to 0, and discards any in-flight request.
  - Reset during XFER withdraws `mem_req_out` on the next edge, even if the same cycle carried an ack.
- **Start:** `start_in` is ignored while `busy_out`=1. `busy_out` rises the cycle after `start_in` is accepted.
- **Request holding:** `mem_req_out`, `mem_addr_out`, `mem_we_out` and `mem_wdata_out` are stable from assertion until the ack cycle inclusive.
- **Back-to-back transfers:** the next request is asserted in the cycle after the ack. There is no idle gap.
- **Latency:** with zero-wait ack, total latency from start to `done_out` is 1 (SETUP) + n + (wb ? 1 : 0) + 1 cycles. Each wait cycle adds 1.
- **Outputs:** all are combinational from registered state plus `mem_ack_in`, `mem_rdata_in` and `rf_rdata_in`. There are no other input-to-output paths.

## Structure
- **Package `bts_pkg`:** state encoding (IDLE, SETUP, XFER, BASEWB, DONE) and the `WORD_BYTES` constant.
- **Sub-module `lowest_set_bit_16`:**
  - Input: 16-bit vector.
  - Outputs: 4-bit index and a 1-bit `none` flag.
  - Used by XFER to select the current register. The popcount lives inline in the top level.

## Test plan
- **STMIA, no writeback.** Start with base=0x100, list=0x0015 (R0, R2, R4), W=0, ack immediate. Required: stores to 0x100, 0x104 and 0x108 with the R0, R2 and R4 values; no `rf_we_out`; `done_out` 5 cycles after start.
- **LDMDB with writeback.** base=R13=0x200, list=0x00F0, W=1, ack after 2 wait cycles each. Required: loads from 0x1F0, 0x1F4, 0x1F8 and 0x1FC into R4–R7; BASEWB writes R13=0x1F0.
- **Load including PC.** LDMIA, list=0x8001, base=0x0. Required: R0 written from 0x0; `pc_load_out` pulses with the data from 0x4; R15 is never written via `rf_we_out`.
- **Base in load list.** LDMIA, W=1, base_reg=R1, list=0x0002. Required: R1 receives the loaded value; BASEWB asserts no write.
- **Empty list and decrement wrap.**
  - Empty list: `done_out` 2 cycles after start, with zero memory requests.
  - Wrap: STMDA with base=0x4 and list=0x0007 starts at 0xFFFFFFFC.
- **Reset mid-transfer and start while busy.** Assert `rst_in` while `mem_req_out`=1. Required: all outputs are 0 the next cycle. A `start_in` held during a busy interval is ignored.
